// File: rtl/pre_filter_pkg.sv
// Shared types and constants for the pre-filter channel arbiter slice.
package pre_filter_pkg;

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   localparam int ACC_FLAG_BIT   = 63;
   localparam int HAZE_MSB       = 47;
   localparam int HAZE_LSB       = 32;
   localparam int FIFO_DEPTH_DEF = 128;
   localparam int CREDIT_W       = $clog2(FIFO_DEPTH_DEF) + 1;

endpackage

// File: rtl/pre_filter_chan_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping mod CH_NUM.
module rr_pick #(
   parameter int CH_NUM = 4
) (
   input  logic [CH_NUM-1:0] req,
   input  logic [2:0]        ptr,
   output logic [CH_NUM-1:0] grant_oh,
   output logic [2:0]        grant_idx,
   output logic              any
);

   int best_d;
   int best_i;
   int d;

   // Pick the requester with the smallest forward distance from ptr.
   always_comb begin
      best_d = CH_NUM;
      best_i = 0;
      d      = 0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (req[i]) begin
            d = (i - int'(ptr) + CH_NUM) % CH_NUM;
            if (d < best_d) begin
               best_d = d;
               best_i = i;
            end
         end
      end
   end

   always_comb begin
      any       = (best_d < CH_NUM);
      grant_idx = 3'(best_i);
      grant_oh  = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         grant_oh[i] = any && (best_i == i);
      end
   end

endmodule

// File: rtl/pre_filter_chan_arbiter.sv
// Round-robin burst arbiter with credit flow control feeding one shared pre_particle_filter.
module pre_filter_chan_arbiter
   import pre_filter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CH_NUM     = 4,
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                                clk_i,
   input  logic                                rst_n_i,
   input  logic [CH_NUM-1:0]                   ch_en_i,
   input  logic [CH_NUM-1:0]                   ch_vld_i,
   input  logic [CH_NUM*(DATA_WIDTH+32)-1:0]   ch_data_i,
   output logic [CH_NUM-1:0]                   ch_rdy_o,
   output logic                                pre_laser_vld_o,
   output logic [DATA_WIDTH+31:0]              pre_laser_data_o,
   output logic [2:0]                          pre_laser_chan_o,
   input  logic                                pre_filter_vld_i,
   output logic                                arb_busy_o,
   output logic [$clog2(FIFO_DEPTH):0]         credit_o,
   output logic                                credit_err_o
);

   localparam int BW = DATA_WIDTH + 32;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t            state, state_nx;
   logic [CH_NUM-1:0] req, pick_oh, gnt_oh;
   logic [2:0]        pick_idx, gnt_idx, rr_ptr;
   logic              pick_any;
   logic [7:0]        beat_cnt;
   logic [CW-1:0]     credit;
   logic              half_tgl, credit_err;
   logic              has_credit, sel_vld, sel_en, accept, last_beat, ret;
   logic              load_grant, burst_end;
   logic [BW-1:0]     sel_data;

   assign req = ch_vld_i & ch_en_i;

   rr_pick #(.CH_NUM(CH_NUM)) u_rr_pick (
      .req       (req),
      .ptr       (rr_ptr),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (gnt_oh[i]) sel_data = ch_data_i[i*BW +: BW];
      end
   end

   assign has_credit = (credit != '0);
   assign sel_vld    = |(ch_vld_i & gnt_oh);
   assign sel_en     = |(ch_en_i & gnt_oh);
   assign ch_rdy_o   = (state == BURST && has_credit && sel_en) ? gnt_oh : '0;
   assign accept     = |(ch_rdy_o & ch_vld_i);
   assign last_beat  = accept && (({1'b0, beat_cnt} + 9'd1) == 9'(BURST_LEN));
   // Credits come back per 32-bit word; the filter pulses once per 16-bit word.
   assign ret        = pre_filter_vld_i & half_tgl;

   assign arb_busy_o   = (state == BURST);
   assign credit_o     = credit;
   assign credit_err_o = credit_err;

   always_comb begin
      state_nx   = state;
      load_grant = 1'b0;
      burst_end  = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any && has_credit) begin
               state_nx   = BURST;
               load_grant = 1'b1;
            end
         end
         BURST: begin
            if (last_beat || !sel_vld || !sel_en) begin
               state_nx  = IDLE;
               burst_end = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= IDLE;
         gnt_oh   <= '0;
         gnt_idx  <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         state <= state_nx;
         if (load_grant) begin
            gnt_oh   <= pick_oh;
            gnt_idx  <= pick_idx;
            beat_cnt <= '0;
         end else if (accept) begin
            beat_cnt <= beat_cnt + 8'd1;
         end
         if (burst_end) begin
            rr_ptr <= (gnt_idx == 3'(CH_NUM - 1)) ? 3'd0 : gnt_idx + 3'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         credit     <= CW'(FIFO_DEPTH);
         half_tgl   <= 1'b0;
         credit_err <= 1'b0;
      end else begin
         half_tgl <= half_tgl ^ pre_filter_vld_i;
         case ({accept, ret})
            2'b10:   credit <= credit - CW'(1);
            2'b01: begin
               if (credit == CW'(FIFO_DEPTH)) credit_err <= 1'b1;
               else                           credit     <= credit + CW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pre_laser_vld_o  <= 1'b0;
         pre_laser_data_o <= '0;
         pre_laser_chan_o <= '0;
      end else begin
         pre_laser_vld_o <= accept;
         if (accept) begin
            pre_laser_data_o <= sel_data;
            pre_laser_chan_o <= gnt_idx;
         end
      end
   end

endmodule
